divisor_mantiza: RTL and testbench

Iterative mantissa divider for the team's 8-bit-mantissa floating-point datapath; it is the division counterpart of the mantissa multiplier. It divides two stored mantissas with implied leading 1, (1.m1)/(1.m2), using restoring division, one quotient bit per clock. It normalizes the quotient to 1.f form and flags when the exponent stage must decrement. It sits beside the multiplier, between operand unpacking and the exponent adjust stage, with valid/ready handshakes on both sides.

---
 rtl/divisor_mantiza_pkg.sv | 21 ++
 rtl/divisor_mantiza_paso.sv | 23 ++
 rtl/divisor_mantiza.sv | 131 +++++++++++++
 tb/tb_divisor_mantiza.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/divisor_mantiza_pkg.sv
// Shared types and sizing for the iterative mantissa divider.
// DIVISOR_MANTIZA_REDONDEO_EN adds one quotient step for round-half-up.
package divisor_mantiza_pkg;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} estado_e;

   localparam int unsigned NB_MANTIZA_DEF = 8;
   localparam int unsigned NB_OPER        = NB_MANTIZA_DEF + 1;
   localparam int unsigned NB_RESTO       = NB_MANTIZA_DEF + 2;

`ifdef DIVISOR_MANTIZA_REDONDEO_EN
   localparam int unsigned PASOS_EXTRA = 3;
`else
   localparam int unsigned PASOS_EXTRA = 2;
`endif

   // One quotient bit per step, so quotient width equals step count.
   localparam int unsigned NB_COCIENTE = NB_MANTIZA_DEF + PASOS_EXTRA;
   localparam int unsigned PASOS       = NB_COCIENTE;

endpackage

// File: rtl/divisor_mantiza_paso.sv
// One combinational restoring-division step: compare, conditionally subtract, shift.
module divisor_mantiza_paso #(
   parameter int unsigned NB_R = 10,
   parameter int unsigned NB_B = 9
) (
   input  logic [NB_R-1:0] i_resto,
   input  logic [NB_B-1:0] i_divisor,
   output logic [NB_R-1:0] o_resto,
   output logic            o_bit
);

   logic [NB_R-1:0] divisor_ext;
   logic [NB_R-1:0] resta;

   always_comb begin
      divisor_ext = {{(NB_R-NB_B){1'b0}}, i_divisor};
      o_bit       = (i_resto >= divisor_ext);
      resta       = o_bit ? (i_resto - divisor_ext) : i_resto;
      // After restoring, resta < divisor, so its MSB is always zero.
      o_resto     = {resta[NB_R-2:0], 1'b0};
   end

endmodule

// File: rtl/divisor_mantiza.sv
// Iterative (1.m1)/(1.m2) restoring divider with normalized quotient and exponent flag.
// DIVISOR_MANTIZA_REDONDEO_EN selects round-half-up instead of truncation.
module divisor_mantiza
   import divisor_mantiza_pkg::*;
#(
   parameter int unsigned NB_MANTIZA = NB_MANTIZA_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [NB_MANTIZA-1:0] i_mantiza_1,
   input  logic [NB_MANTIZA-1:0] i_mantiza_2,
   input  logic                  i_valido,
   output logic                  o_listo,
   output logic [NB_MANTIZA-1:0] o_mantiza,
   output logic                  o_aviso_exponente,
   output logic                  o_valido,
   input  logic                  i_listo
);

   localparam int unsigned NB_A = NB_MANTIZA + 1;
   localparam int unsigned NB_R = NB_MANTIZA + 2;
   localparam int unsigned NB_Q = NB_MANTIZA + PASOS_EXTRA;
   localparam int unsigned NB_C = $clog2(NB_Q + 1);

   estado_e               estado_q, estado_d;
   logic [NB_A-1:0]       b_q, b_d;
   logic [NB_R-1:0]       r_q, r_d;
   // The last quotient bit goes straight into normalization, so it is never stored.
   logic [NB_Q-2:0]       q_q, q_d;
   logic [NB_C-1:0]       cont_q, cont_d;
   logic [NB_MANTIZA-1:0] mantiza_q, mantiza_d;
   logic                  aviso_q, aviso_d;

   logic [NB_R-1:0]       r_paso;
   logic                  bit_paso;
   logic [NB_Q-1:0]       q_final;
   logic [NB_MANTIZA-1:0] mantiza_norm;
   logic                  aviso_norm;

   divisor_mantiza_paso #(
      .NB_R (NB_R),
      .NB_B (NB_A)
   ) u_paso (
      .i_resto   (r_q),
      .i_divisor (b_q),
      .o_resto   (r_paso),
      .o_bit     (bit_paso)
   );

   assign q_final = {q_q, bit_paso};

   always_comb begin
      aviso_norm = ~q_final[NB_Q-1];
`ifdef DIVISOR_MANTIZA_REDONDEO_EN
      if (q_final[NB_Q-1]) begin
         mantiza_norm = q_final[NB_Q-2:2] + NB_MANTIZA'(q_final[1]);
      end else begin
         mantiza_norm = q_final[NB_Q-3:1] + NB_MANTIZA'(q_final[0]);
      end
`else
      if (q_final[NB_Q-1]) begin
         mantiza_norm = q_final[NB_Q-2:1];
      end else begin
         mantiza_norm = q_final[NB_Q-3:0];
      end
`endif
   end

   always_comb begin
      estado_d  = estado_q;
      b_d       = b_q;
      r_d       = r_q;
      q_d       = q_q;
      cont_d    = cont_q;
      mantiza_d = mantiza_q;
      aviso_d   = aviso_q;
      unique case (estado_q)
         StIdle: begin
            if (i_valido) begin
               b_d      = {1'b1, i_mantiza_2};
               r_d      = {2'b01, i_mantiza_1};
               q_d      = '0;
               cont_d   = '0;
               estado_d = StCalc;
            end
         end
         StCalc: begin
            r_d    = r_paso;
            q_d    = q_final[NB_Q-2:0];
            cont_d = cont_q + 1'b1;
            if (cont_q == NB_C'(NB_Q - 1)) begin
               mantiza_d = mantiza_norm;
               aviso_d   = aviso_norm;
               estado_d  = StDone;
            end
         end
         StDone: begin
            if (i_listo) begin
               estado_d = StIdle;
            end
         end
         default: estado_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         estado_q  <= StIdle;
         b_q       <= '0;
         r_q       <= '0;
         q_q       <= '0;
         cont_q    <= '0;
         mantiza_q <= '0;
         aviso_q   <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         b_q       <= b_d;
         r_q       <= r_d;
         q_q       <= q_d;
         cont_q    <= cont_d;
         mantiza_q <= mantiza_d;
         aviso_q   <= aviso_d;
      end
   end

   assign o_listo           = (estado_q == StIdle);
   assign o_valido          = (estado_q == StDone);
   assign o_mantiza         = mantiza_q;
   assign o_aviso_exponente = aviso_q;

endmodule

// File: tb/tb_divisor_mantiza.sv
// Directed self-checking bench for divisor_mantiza with hand-computed quotients.
module tb_divisor_mantiza;

`ifdef DIVISOR_MANTIZA_REDONDEO_EN
   localparam int LATENCIA = 11;
   localparam logic [7:0] EXP_0180 = 8'h57;
`else
   localparam int LATENCIA = 10;
   localparam logic [7:0] EXP_0180 = 8'h56;
`endif

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic [7:0] i_mantiza_1 = '0;
   logic [7:0] i_mantiza_2 = '0;
   logic       i_valido = 1'b0;
   logic       i_listo = 1'b1;
   logic       o_listo;
   logic [7:0] o_mantiza;
   logic       o_aviso_exponente;
   logic       o_valido;

   int n_checks = 0;
   int n_fails  = 0;

   divisor_mantiza dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_mantiza_1       (i_mantiza_1),
      .i_mantiza_2       (i_mantiza_2),
      .i_valido          (i_valido),
      .o_listo           (o_listo),
      .o_mantiza         (o_mantiza),
      .o_aviso_exponente (o_aviso_exponente),
      .o_valido          (o_valido),
      .i_listo           (i_listo)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Accepts one operation and waits (bounded) for o_valido; returns observed latency.
   task automatic launch(input logic [7:0] m1, input logic [7:0] m2, output int lat);
      i_mantiza_1 = m1;
      i_mantiza_2 = m2;
      i_valido    = 1'b1;
      tick();
      i_valido = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (o_valido) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] m1, input logic [7:0] m2,
                         input logic [7:0] exp_m, input logic exp_a);
      int lat;
      check_eq({tag, "_listo_pre"}, o_listo, 1);
      launch(m1, m2, lat);
      check_eq({tag, "_lat"}, lat, LATENCIA);
      check_eq({tag, "_mantiza"}, o_mantiza, exp_m);
      check_eq({tag, "_aviso"}, o_aviso_exponente, exp_a);
      tick();
      // i_listo was already high: result visible for exactly one cycle
      check_eq({tag, "_valido_post"}, o_valido, 0);
      check_eq({tag, "_listo_post"}, o_listo, 1);
   endtask

   initial begin
      logic [7:0] held_m;
      logic       held_a;
      int         lat;

      tick();
      tick();
      check_eq("rst_listo", o_listo, 1);
      check_eq("rst_valido", o_valido, 0);
      check_eq("rst_mantiza", o_mantiza, 0);
      check_eq("rst_aviso", o_aviso_exponente, 0);
      i_rst_n = 1'b1;
      tick();

      run_op("uno",      8'h00, 8'h00, 8'h00, 1'b0);
      run_op("tres_med", 8'h80, 8'h00, 8'h80, 1'b0);
      run_op("max",      8'hFF, 8'h00, 8'hFF, 1'b0);
      run_op("dos_ter",  8'h00, 8'h80, 8'h55, 1'b1);
      run_op("trunc",    8'h01, 8'h80, EXP_0180, 1'b1);

      // Downstream stall: outputs must hold while operands and i_valido toggle
      i_listo = 1'b0;
      launch(8'h80, 8'h00, lat);
      check_eq("stall_lat", lat, LATENCIA);
      held_m = o_mantiza;
      held_a = o_aviso_exponente;
      check_eq("stall_mantiza0", held_m, 8'h80);
      for (int c = 0; c < 5; c++) begin
         i_mantiza_1 = 8'(c * 37 + 5);
         i_mantiza_2 = 8'(c * 91 + 3);
         i_valido    = c[0];
         tick();
         check_eq("stall_valido", o_valido, 1);
         check_eq("stall_listo", o_listo, 0);
         check_eq("stall_mantiza", o_mantiza, 8'h80);
         check_eq("stall_aviso", o_aviso_exponente, 0);
      end
      i_valido = 1'b0;
      i_listo  = 1'b1;
      tick();
      check_eq("release_listo", o_listo, 1);
      check_eq("release_valido", o_valido, 0);
      tick();
      check_eq("idle_stays", o_listo, 1);

      // Abort mid-CALC: reset after step 4
      i_mantiza_1 = 8'hFF;
      i_mantiza_2 = 8'h00;
      i_valido    = 1'b1;
      tick();
      i_valido = 1'b0;
      for (int s = 0; s < 4; s++) tick();
      check_eq("abort_busy", o_listo, 0);
      i_rst_n = 1'b0;
      tick();
      check_eq("abort_listo", o_listo, 1);
      check_eq("abort_valido", o_valido, 0);
      check_eq("abort_mantiza", o_mantiza, 0);
      check_eq("abort_aviso", o_aviso_exponente, 0);
      i_rst_n = 1'b1;
      tick();
      run_op("post_rst", 8'h00, 8'h80, 8'h55, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
